s1_rr_sched: RTL and testbench

- Round-robin scheduler that shares one registered 4:1 mux cell (S1) between four requesters.
- Each requester presents a `size`-bit operand and raises `req`.
- The scheduler picks a winner, drives the S1 select lines, waits for the S1 output register, then returns the result with a one-cycle ack to the winner.
- Sits between the requester bank and the S1 instance; instantiates no S1 itself.

---
 rtl/s1_rr_sched_pkg.sv | 19 +
 rtl/s1_rr_sched_pick4.sv | 29 ++
 rtl/s1_rr_sched.sv | 115 +++++++++++
 tb/tb_s1_rr_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/s1_rr_sched_pkg.sv
// Shared definitions for the S1 round-robin scheduler: state encoding, requester
// count and the grant-index to S1 select-line mapping.
package s1_rr_sched_pkg;

    localparam int unsigned NReq = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSel  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    // Returns {a1, b1, a0}; a1 and b1 both carry the upper grant bit.
    function automatic logic [2:0] sel_enc(input logic [1:0] gnt);
        return {gnt[1], gnt[1], gnt[0]};
    endfunction

endpackage

// File: rtl/s1_rr_sched_pick4.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping mod 4.
module rr_pick4
    import s1_rr_sched_pkg::*;
(
    input  logic [NReq-1:0] req_i,
    input  logic [1:0]      ptr_i,
    output logic [1:0]      gnt_idx_o,
    output logic            any_o
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt_idx_o = 2'd0;
        found     = 1'b0;
        idx       = 2'd0;
        for (int k = 0; k < NReq; k++) begin
            idx = 2'(ptr_i + 2'(k));
            if (!found && req_i[idx]) begin
                gnt_idx_o = idx;
                found     = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/s1_rr_sched.sv
// Round-robin scheduler sharing one registered 4:1 mux cell (S1) between four requesters.
// Each transaction runs IDLE -> SEL -> WAIT -> DONE with a one-cycle ack in DONE.
module s1_rr_sched
    import s1_rr_sched_pkg::*;
#(
    parameter int unsigned size = 5
) (
    input  logic            clk,
    input  logic            CLR,
    input  logic [3:0]      req,
    input  logic [size-1:0] din0,
    input  logic [size-1:0] din1,
    input  logic [size-1:0] din2,
    input  logic [size-1:0] din3,
    output logic [size-1:0] cell_d00,
    output logic [size-1:0] cell_d01,
    output logic [size-1:0] cell_d10,
    output logic [size-1:0] cell_d11,
    output logic            cell_a1,
    output logic            cell_b1,
    output logic            cell_a0,
    output logic            cell_clr,
    input  logic [size-1:0] cell_out,
    output logic [3:0]      ack,
    output logic [size-1:0] dout,
    output logic            dout_valid,
    output logic [1:0]      dout_src
);

    state_e            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic [2:0]        sel_q, sel_d;
    logic [NReq-1:0]   ack_q, ack_d;
    logic [size-1:0]   dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic [1:0]        dout_src_q, dout_src_d;
    logic [1:0]        pick_idx;
    logic              pick_any;

    rr_pick4 u_pick (
        .req_i     (req),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        ack_d        = '0;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        dout_src_d   = dout_src_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    sel_d   = sel_enc(pick_idx);
                    state_d = StSel;
                end
            end
            StSel:  state_d = StWait;
            StWait: begin
                // S1 captured the selected operand at the end of SEL.
                dout_d         = cell_out;
                dout_src_d     = grant_q;
                dout_valid_d   = 1'b1;
                ack_d[grant_q] = 1'b1;
                rr_ptr_d       = 2'(grant_q + 2'd1);
                state_d        = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q      <= StIdle;
            rr_ptr_q     <= 2'd0;
            grant_q      <= 2'd0;
            sel_q        <= 3'd0;
            ack_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_src_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            ack_q        <= ack_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_src_q   <= dout_src_d;
        end
    end

    assign cell_d00   = din0;
    assign cell_d01   = din1;
    assign cell_d10   = din2;
    assign cell_d11   = din3;
    assign cell_a1    = sel_q[2];
    assign cell_b1    = sel_q[1];
    assign cell_a0    = sel_q[0];
    assign cell_clr   = CLR;
    assign ack        = ack_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_src   = dout_src_q;

endmodule

// File: tb/tb_s1_rr_sched.sv
// Self-checking bench for s1_rr_sched: a behavioural S1 cell, a transaction-level
// reference model, directed boundary scenarios and a randomized phase.
module tb_s1_rr_sched;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         clr;
    logic [3:0]   req;
    logic [W-1:0] din_a [4];
    logic [W-1:0] cell_d00, cell_d01, cell_d10, cell_d11, cell_out, dout;
    logic         cell_a1, cell_b1, cell_a0, cell_clr, dout_valid;
    logic [3:0]   ack;
    logic [1:0]   dout_src;

    int tests = 0;
    int fails = 0;

    // Reference model state (transaction level)
    int           m_phase, m_ptr, m_grant, m_src;
    logic [W-1:0] m_cap, m_dout;
    logic         m_valid;
    logic [3:0]   m_ack;

    always #5 clk = ~clk;

    s1_rr_sched #(.size(W)) dut (
        .clk        (clk),
        .CLR        (clr),
        .req        (req),
        .din0       (din_a[0]),
        .din1       (din_a[1]),
        .din2       (din_a[2]),
        .din3       (din_a[3]),
        .cell_d00   (cell_d00),
        .cell_d01   (cell_d01),
        .cell_d10   (cell_d10),
        .cell_d11   (cell_d11),
        .cell_a1    (cell_a1),
        .cell_b1    (cell_b1),
        .cell_a0    (cell_a0),
        .cell_clr   (cell_clr),
        .cell_out   (cell_out),
        .ack        (ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_src   (dout_src)
    );

    // Behavioural S1: registered 4:1 mux with synchronous clear.
    always @(posedge clk) begin
        if (cell_clr) cell_out <= '0;
        else begin
            case ({cell_a1 & cell_b1, cell_a0})
                2'b00:   cell_out <= cell_d00;
                2'b01:   cell_out <= cell_d01;
                2'b10:   cell_out <= cell_d10;
                default: cell_out <= cell_d11;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        m_valid = 1'b0;
        m_ack   = 4'd0;
        if (clr) begin
            m_phase = 0; m_ptr = 0; m_grant = 0; m_src = 0; m_dout = '0;
        end else begin
            case (m_phase)
                0: if (req != 4'd0) begin
                    for (int k = 3; k >= 0; k--)
                        if (req[(m_ptr + k) % 4]) m_grant = (m_ptr + k) % 4;
                    m_phase = 1;
                end
                1: begin m_cap = din_a[m_grant]; m_phase = 2; end
                2: begin
                    m_dout  = m_cap;
                    m_src   = m_grant;
                    m_valid = 1'b1;
                    m_ack   = 4'(1 << m_grant);
                    m_ptr   = (m_grant + 1) % 4;
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("ack", ack, m_ack);
        chk("dout_valid", dout_valid, m_valid);
        chk("dout", dout, m_dout);
        chk("dout_src", dout_src, m_src);
        chk("cell_a1", cell_a1, m_grant / 2);
        chk("cell_b1", cell_b1, m_grant / 2);
        chk("cell_a0", cell_a0, m_grant % 2);
        chk("cell_clr", cell_clr, clr);
        chk("cell_d", {cell_d11, cell_d10, cell_d01, cell_d00},
            {din_a[3], din_a[2], din_a[1], din_a[0]});
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ack == 4'd0 && n < 20);
        chk("ack_within_bound", 32'(ack != 4'd0), 1);
    endtask

    initial begin
        int n;
        m_phase = 0; m_ptr = 0; m_grant = 0; m_src = 0;
        m_cap = '0; m_dout = '0; m_valid = 1'b0; m_ack = 4'd0;
        clr = 1'b1;
        req = 4'd0;
        for (int i = 0; i < 4; i++) din_a[i] = '0;

        // Reset state
        step();
        chk("rst_ack", ack, 4'd0);
        chk("rst_dout", dout, 0);
        chk("rst_sel", {cell_a1, cell_b1, cell_a0}, 3'b000);
        clr = 1'b0;

        // Single request from requester 2
        din_a[2] = 5'h15;
        req = 4'b0100;
        step();
        chk("single_sel", {cell_a1, cell_b1, cell_a0}, 3'b110);
        step();
        step();
        chk("single_ack", ack, 4'b0100);
        chk("single_dout", dout, 5'h15);
        chk("single_src", dout_src, 2);
        chk("single_valid", dout_valid, 1);
        req = 4'b0000;
        step();
        chk("single_ack_one_cycle", ack, 4'd0);

        // Wrap: pointer is now 3, requesters 3 and 0 pending
        din_a[3] = 5'h0a; din_a[0] = 5'h05;
        req = 4'b1001;
        wait_ack(n);
        chk("wrap_first", dout_src, 3);
        req = 4'b0001;
        wait_ack(n);
        chk("wrap_second", dout_src, 0);
        chk("wrap_second_dout", dout, 5'h05);
        req = 4'b0000;
        step();

        // All four requesting after reset
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) din_a[i] = 5'(i + 1);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(n);
            chk("all4_src", dout_src, i);
            chk("all4_dout", dout, i + 1);
            chk("all4_spacing", n, (i == 0) ? 3 : 4);
        end
        req = 4'b0000;
        step();

        // Request dropped while in WAIT
        din_a[1] = 5'h09;
        req = 4'b0010;
        step();
        step();
        req = 4'b0000;
        wait_ack(n);
        chk("drop_ack", ack, 4'b0010);
        chk("drop_dout", dout, 5'h09);
        for (int i = 0; i < 4; i++) step();

        // Reset during WAIT, then pending request restarts
        din_a[2] = 5'h07;
        req = 4'b0100;
        step();
        step();
        clr = 1'b1;
        step();
        chk("clr_ack", ack, 4'd0);
        chk("clr_dout", dout, 0);
        chk("clr_valid", dout_valid, 0);
        chk("clr_src", dout_src, 0);
        chk("clr_cell_out", cell_out, 0);
        clr = 1'b0;
        wait_ack(n);
        chk("restart_latency", n, 3);
        chk("restart_src", dout_src, 2);
        chk("restart_dout", dout, 5'h07);
        req = 4'b0000;
        step();

        // CLR and req together: CLR wins, first grant then goes to requester 0
        clr = 1'b1;
        req = 4'b1111;
        step();
        chk("clrreq_sel", {cell_a1, cell_b1, cell_a0}, 3'b000);
        chk("clrreq_ack", ack, 4'd0);
        clr = 1'b0;
        wait_ack(n);
        chk("clrreq_first", dout_src, 0);
        req = 4'b0000;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 30) req = 4'($urandom);
            for (int j = 0; j < 4; j++)
                if ($urandom_range(0, 99) < 30) din_a[j] = 5'($urandom);
            clr = ($urandom_range(0, 99) < 3);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
